// File: rtl/fft_issue_ctrl.sv
// rtl/fft_issue_ctrl.sv - custom-0 FFT issue sequencer: operand check, accelerator launch, stall and status writeback
// Holds the pipeline from the fft_start cycle until the status word is written back.
module fft_issue_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int LOG2N_MAX = 10,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fft_start,
  input  logic [31:0]       rs1_val,
  input  logic [31:0]       rs2_val,
  input  logic [4:0]        rd_addr,
  output logic              stall,
  output logic              busy,
  output logic              acc_start,
  output logic              acc_abort,
  output logic [ADDR_W-1:0] acc_base,
  output logic [3:0]        acc_log2n,
  input  logic              acc_busy,
  input  logic              acc_done,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0] L_MAX = 4'(LOG2N_MAX);

  typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, WAIT, WB} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  logic          operands_ok;

  function automatic logic [15:0] sat16(input logic [CW-1:0] v);
    logic [31:0] ext;
    ext = 32'(v);
    return (ext > 32'h0000_FFFF) ? 16'hFFFF : ext[15:0];
  endfunction

  assign cnt_inc = cnt + CW'(1);
  // >= rather than == so a launch granted on the last cycle still times out in WAIT
  assign timeout_hit = (cnt >= T_LAST);
  assign operands_ok = (acc_log2n >= 4'd2) && (acc_log2n <= L_MAX) && (acc_base[2:0] == 3'b000);

  assign stall     = ((state == IDLE) && fft_start) || (state == CHECK) || (state == LAUNCH) || (state == WAIT);
  assign busy      = (state != IDLE);
  assign wb_en     = (state == WB);
  assign acc_start = (state == LAUNCH) && !acc_busy;
  assign acc_abort = timeout_hit && (((state == LAUNCH) && acc_busy) || ((state == WAIT) && !acc_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_base  <= '0;
      acc_log2n <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fft_start) begin
            acc_base  <= rs1_val[ADDR_W-1:0];
            acc_log2n <= rs2_val[3:0];
            wb_rd     <= rd_addr;
            cnt       <= '0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (operands_ok) begin
            state <= LAUNCH;
          end else begin
            wb_data <= {sat16(cnt), 14'b0, 2'd2};
            state   <= WB;
          end
        end
        LAUNCH: begin
          cnt <= cnt_inc;
          if (!acc_busy) begin
            state <= WAIT;
          end else if (timeout_hit) begin
            wb_data <= {sat16(cnt), 14'b0, 2'd3};
            state   <= WB;
          end
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (acc_done) begin
            wb_data <= {sat16(cnt_inc), 14'b0, 2'd0};
            state   <= WB;
          end else if (timeout_hit) begin
            wb_data <= {sat16(cnt), 14'b0, 2'd3};
            state   <= WB;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_issue_ctrl.sv
// tb/tb_fft_issue_ctrl.sv - directed table-driven bench for fft_issue_ctrl
// Instance a uses the default TIMEOUT, instance b uses TIMEOUT = 16.
module tb_fft_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_addr = '0;

  logic a_fft_start = 0, a_acc_busy = 0, a_acc_done = 0;
  logic a_stall, a_busy, a_acc_start, a_acc_abort, a_wb_en;
  logic [31:0] a_acc_base, a_wb_data;
  logic [3:0] a_acc_log2n;
  logic [4:0] a_wb_rd;

  logic b_fft_start = 0, b_acc_busy = 0, b_acc_done = 0;
  logic b_stall, b_busy, b_acc_start, b_acc_abort, b_wb_en;
  logic [31:0] b_acc_base, b_wb_data;
  logic [3:0] b_acc_log2n;
  logic [4:0] b_wb_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_issue_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .fft_start(a_fft_start), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd_addr(rd_addr), .stall(a_stall), .busy(a_busy), .acc_start(a_acc_start), .acc_abort(a_acc_abort),
    .acc_base(a_acc_base), .acc_log2n(a_acc_log2n), .acc_busy(a_acc_busy), .acc_done(a_acc_done),
    .wb_en(a_wb_en), .wb_rd(a_wb_rd), .wb_data(a_wb_data)
  );

  fft_issue_ctrl #(.TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .fft_start(b_fft_start), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd_addr(rd_addr), .stall(b_stall), .busy(b_busy), .acc_start(b_acc_start), .acc_abort(b_acc_abort),
    .acc_base(b_acc_base), .acc_log2n(b_acc_log2n), .acc_busy(b_acc_busy), .acc_done(b_acc_done),
    .wb_en(b_wb_en), .wb_rd(b_wb_rd), .wb_data(b_wb_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          inst;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rd;
    int          busy_n;
    int          dly;
    int          e_start;
    int          e_wb;
    int          e_abort;
    logic [31:0] e_wbd;
  } vec_t;

  vec_t vecs[12];

  // Cycle 0 is the fft_start cycle (T); inputs are set on the falling edge, outputs read 1 ns later.
  task automatic run(input vec_t v, input int idx);
    int st_cyc = -1, wb_cyc = -1, n_start = 0, n_abort = 0, proto_bad = 0;
    logic [31:0] got_wbd = '0, got_base = '0;
    logic [4:0] got_rd = '0;
    logic [3:0] got_l2n = '0;
    logic s_stall, s_start, s_abort, s_wb;
    string tag;
    tag = $sformatf("v%0d", idx);
    rs1_val = v.r1; rs2_val = v.r2; rd_addr = v.rd;
    for (int c = 0; c < 100 && wb_cyc < 0; c++) begin
      @(negedge clk);
      if (v.inst) begin
        b_fft_start = 1'b1;
        b_acc_busy  = (c >= 2) && (c < 2 + v.busy_n);
        b_acc_done  = (v.dly >= 0) && (st_cyc >= 0) && (c == st_cyc + v.dly);
      end else begin
        a_fft_start = 1'b1;
        a_acc_busy  = (c >= 2) && (c < 2 + v.busy_n);
        a_acc_done  = (v.dly >= 0) && (st_cyc >= 0) && (c == st_cyc + v.dly);
      end
      #1;
      s_stall = v.inst ? b_stall : a_stall;
      s_start = v.inst ? b_acc_start : a_acc_start;
      s_abort = v.inst ? b_acc_abort : a_acc_abort;
      s_wb    = v.inst ? b_wb_en : a_wb_en;
      if (s_start) begin
        n_start++; st_cyc = c;
        got_base = v.inst ? b_acc_base : a_acc_base;
        got_l2n  = v.inst ? b_acc_log2n : a_acc_log2n;
      end
      if (s_abort) n_abort++;
      if (s_start && s_abort) proto_bad++;
      if (s_stall === s_wb) proto_bad++;
      if (s_wb) begin
        wb_cyc  = c;
        got_wbd = v.inst ? b_wb_data : a_wb_data;
        got_rd  = v.inst ? b_wb_rd : a_wb_rd;
      end
    end
    @(negedge clk);
    a_fft_start = 0; a_acc_busy = 0; a_acc_done = 0;
    b_fft_start = 0; b_acc_busy = 0; b_acc_done = 0;
    #1;
    chk({tag, "_start_cyc"}, st_cyc, v.e_start);
    chk({tag, "_n_start"}, n_start, (v.e_start >= 0) ? 1 : 0);
    chk({tag, "_wb_cyc"}, wb_cyc, v.e_wb);
    chk({tag, "_wb_data"}, got_wbd, v.e_wbd);
    chk({tag, "_wb_rd"}, {27'b0, got_rd}, {27'b0, v.rd});
    chk({tag, "_n_abort"}, n_abort, v.e_abort);
    chk({tag, "_stall_proto"}, proto_bad, 0);
    chk({tag, "_idle_after"}, {30'b0, v.inst ? {b_busy, b_stall} : {a_busy, a_stall}}, 0);
    if (v.e_start >= 0) begin
      chk({tag, "_acc_base"}, got_base, v.r1);
      chk({tag, "_acc_log2n"}, {28'b0, got_l2n}, {28'b0, v.r2[3:0]});
    end
  endtask

  initial begin
    //           inst r1            r2     rd     busy dly  start wb  abort wb_data
    vecs[0]  = '{1'b0, 32'h1000,     32'd8,  5'd5,  0,  20,  2, 23, 0, 32'h0015_0000};
    vecs[1]  = '{1'b0, 32'h1000,     32'd1,  5'd3,  0,  -1, -1,  2, 0, 32'h0000_0002};
    vecs[2]  = '{1'b0, 32'h1000,     32'd11, 5'd3,  0,  -1, -1,  2, 0, 32'h0000_0002};
    vecs[3]  = '{1'b0, 32'h1004,     32'd8,  5'd3,  0,  -1, -1,  2, 0, 32'h0000_0002};
    vecs[4]  = '{1'b0, 32'h2000,     32'd4,  5'd7,  5,   3,  7, 11, 0, 32'h0009_0000};
    vecs[5]  = '{1'b0, 32'h8,        32'h1A, 5'd0,  0,   1,  2,  4, 0, 32'h0002_0000};
    vecs[6]  = '{1'b0, 32'hFFFFFFF8, 32'd2,  5'd31, 0,   5,  2,  8, 0, 32'h0006_0000};
    vecs[7]  = '{1'b0, 32'h1002,     32'd0,  5'd1,  0,  -1, -1,  2, 0, 32'h0000_0002};
    vecs[8]  = '{1'b1, 32'h40,       32'd5,  5'd9,  0,  -1,  2, 18, 1, 32'h000F_0003};
    vecs[9]  = '{1'b1, 32'h40,       32'd5,  5'd9,  0,  15,  2, 18, 0, 32'h0010_0000};
    vecs[10] = '{1'b1, 32'h40,       32'd5,  5'd9, 100, -1, -1, 18, 1, 32'h000F_0003};
    vecs[11] = '{1'b1, 32'h48,       32'd10, 5'd2,  0,  14,  2, 17, 0, 32'h000F_0000};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", {27'b0, a_stall, a_busy, a_acc_start, a_acc_abort, a_wb_en}, 0);
    chk("reset_regs", a_acc_base | a_wb_data | {28'b0, a_acc_log2n} | {27'b0, a_wb_rd}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run(vecs[i], i);

    // Reset while waiting on the accelerator.
    rs1_val = 32'h1000; rs2_val = 32'd8; rd_addr = 5'd6;
    @(negedge clk); a_fft_start = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("mid_wait_busy", {31'b0, a_busy}, 1);
    rst_n = 1'b0; a_fft_start = 1'b0;
    #1;
    chk("rst_mid_ctrl", {27'b0, a_stall, a_busy, a_acc_start, a_acc_abort, a_wb_en}, 0);
    chk("rst_mid_regs", a_acc_base | a_wb_data | {28'b0, a_acc_log2n} | {27'b0, a_wb_rd}, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_stall", {31'b0, a_stall}, 0);
    @(negedge clk); a_acc_done = 1'b1;
    #1;
    chk("spurious_done_wb", {30'b0, a_wb_en, a_busy}, 0);
    @(negedge clk); a_acc_done = 1'b0;
    #1;
    chk("spurious_done_after", {29'b0, a_wb_en, a_busy, a_stall}, 0);
    chk("spurious_done_data", a_wb_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
